// File: rtl/uarch_pkg.sv
// Shared core micro-architecture types: register index/word, operand-fetch
// FSM states and the PC read-ahead offset.
package uarch_pkg;

   typedef logic [3:0]  reg_index;
   typedef logic [31:0] word;

   typedef enum logic [2:0] {
      OPF_IDLE,
      OPF_READ_RN,
      OPF_READ_RM,
      OPF_READ_RS,
      OPF_DRAIN,
      OPF_HOLD
   } reg_opfetch_state;

   localparam word REG_PC_OFFSET = 32'd8;

   // First operand at or after slot 'from' that needs a file read, else DRAIN.
   function automatic reg_opfetch_state opf_next_read(logic [2:0] need, logic [1:0] from);
      if (from == 2'd0 && need[0]) return OPF_READ_RN;
      if (from <= 2'd1 && need[1]) return OPF_READ_RM;
      if (from <= 2'd2 && need[2]) return OPF_READ_RS;
      return OPF_DRAIN;
   endfunction

endpackage

// File: rtl/core_reg_operand_fetch.sv
// Operand fetch: serialises up to three register-file reads through the single
// read port, keeps held operands coherent with writeback, and hands off a bundle.
module core_reg_operand_fetch
   import uarch_pkg::*;
#(
   parameter word PC_OFFSET = REG_PC_OFFSET
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  logic     in_valid,
   output logic     in_ready,
   input  logic     rn_use,
   input  logic     rm_use,
   input  logic     rs_use,
   input  logic     rn_pc,
   input  logic     rm_pc,
   input  logic     rs_pc,
   input  reg_index rn_index,
   input  reg_index rm_index,
   input  reg_index rs_index,
   input  word      pc,
   output reg_index rd_index,
   input  word      rd_value,
   input  logic     wr_enable,
   input  reg_index wr_index,
   input  word      wr_value,
   output logic     out_valid,
   input  logic     out_ready,
   output word      rn_value,
   output word      rm_value,
   output word      rs_value
);

   reg_opfetch_state   state, state_nxt;
   logic [2:0]         use_in, pc_in, need_in;
   reg_index [2:0]     idx_in;
   logic [2:0]         use_q, pcop_q, need_q;
   reg_index [2:0]     idx_q;
   logic               cap_pend_q;
   logic [1:0]         cap_slot_q;
   logic               issue;
   logic [1:0]         issue_slot;
   logic               accept;
   word                vals [3];

   assign use_in  = {rs_use, rm_use, rn_use};
   assign pc_in   = {rs_pc, rm_pc, rn_pc};
   assign idx_in  = {rs_index, rm_index, rn_index};
   assign need_in = use_in & ~pc_in;
   assign need_q  = use_q & ~pcop_q;

   assign in_ready  = (state == OPF_IDLE);
   assign out_valid = (state == OPF_HOLD);
   assign accept    = in_ready & in_valid & ~flush;

   always_comb begin
      state_nxt  = state;
      rd_index   = '0;
      issue      = 1'b0;
      issue_slot = 2'd0;
      unique case (state)
         OPF_IDLE:    if (in_valid) state_nxt = opf_next_read(need_in, 2'd0);
         OPF_READ_RN: begin
            rd_index   = idx_q[0];
            issue      = 1'b1;
            issue_slot = 2'd0;
            state_nxt  = opf_next_read(need_q, 2'd1);
         end
         OPF_READ_RM: begin
            rd_index   = idx_q[1];
            issue      = 1'b1;
            issue_slot = 2'd1;
            state_nxt  = opf_next_read(need_q, 2'd2);
         end
         OPF_READ_RS: begin
            rd_index   = idx_q[2];
            issue      = 1'b1;
            issue_slot = 2'd2;
            state_nxt  = OPF_DRAIN;
         end
         OPF_DRAIN:   state_nxt = OPF_HOLD;
         OPF_HOLD:    if (out_ready) state_nxt = OPF_IDLE;
         default:     state_nxt = OPF_IDLE;
      endcase
      if (flush) state_nxt = OPF_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= OPF_IDLE;
         use_q      <= '0;
         pcop_q     <= '0;
         idx_q      <= '0;
         cap_pend_q <= 1'b0;
         cap_slot_q <= 2'd0;
      end else begin
         state      <= state_nxt;
         // The read issued this cycle returns data next cycle; remember which slot.
         cap_pend_q <= issue & ~flush;
         cap_slot_q <= issue_slot;
         if (accept) begin
            use_q  <= use_in;
            pcop_q <= pc_in;
            idx_q  <= idx_in;
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_slot
      word  val;
      logic captured;
      logic hit;

      assign hit     = wr_enable && (wr_index == idx_q[g]);
      assign vals[g] = val;

      // A write landing in the capture cycle beats the stale file data.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            val      <= '0;
            captured <= 1'b0;
         end else if (flush) begin
            val      <= '0;
            captured <= 1'b0;
         end else if (accept) begin
            val      <= (use_in[g] && pc_in[g]) ? pc + PC_OFFSET : '0;
            captured <= 1'b0;
         end else if (cap_pend_q && cap_slot_q == 2'(g)) begin
            val      <= hit ? wr_value : rd_value;
            captured <= 1'b1;
         end else if (captured && hit) begin
            val      <= wr_value;
         end
      end
   end

   assign rn_value = vals[0];
   assign rm_value = vals[1];
   assign rs_value = vals[2];

endmodule

// File: tb/tb_core_reg_operand_fetch.sv
// Directed and randomized checks of core_reg_operand_fetch against a register
// file model and an "operand always equals the file" reference.
module tb_core_reg_operand_fetch;
   import uarch_pkg::*;

   logic     clk = 1'b0;
   logic     rst, flush, in_valid, in_ready;
   logic     rn_use, rm_use, rs_use, rn_pc, rm_pc, rs_pc;
   reg_index rn_index, rm_index, rs_index, rd_index, wr_index;
   word      pc, rd_value, wr_value, rn_value, rm_value, rs_value;
   logic     wr_enable, out_valid, out_ready;

   word      mem [16];
   reg_index rd_q;
   int       nvec = 0;
   int       nerr = 0;

   logic [2:0] m_use, m_pcf;
   reg_index   m_idx [3];
   word        m_pc;

   core_reg_operand_fetch dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .rn_use(rn_use), .rm_use(rm_use), .rs_use(rs_use),
      .rn_pc(rn_pc), .rm_pc(rm_pc), .rs_pc(rs_pc),
      .rn_index(rn_index), .rm_index(rm_index), .rs_index(rs_index), .pc(pc),
      .rd_index(rd_index), .rd_value(rd_value),
      .wr_enable(wr_enable), .wr_index(wr_index), .wr_value(wr_value),
      .out_valid(out_valid), .out_ready(out_ready),
      .rn_value(rn_value), .rm_value(rm_value), .rs_value(rs_value)
   );

   always #5 clk = ~clk;

   // Register file: write at the edge, data for a presented index one cycle later.
   always @(posedge clk) begin
      if (wr_enable) mem[wr_index] <= wr_value;
      rd_q <= rd_index;
   end
   assign rd_value = mem[rd_q];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input word obs, input word exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [2:0] u, input logic [2:0] p,
                      input reg_index a, input reg_index b, input reg_index c, input word pcv);
      rn_use = u[0]; rm_use = u[1]; rs_use = u[2];
      rn_pc  = p[0]; rm_pc  = p[1]; rs_pc  = p[2];
      rn_index = a; rm_index = b; rs_index = c; pc = pcv;
      in_valid = 1'b1;
      m_use = u; m_pcf = p; m_idx[0] = a; m_idx[1] = b; m_idx[2] = c; m_pc = pcv;
   endtask

   task automatic wr_reg(input reg_index i, input word v);
      wr_enable = 1'b1; wr_index = i; wr_value = v;
      step();
      wr_enable = 1'b0;
   endtask

   task automatic rnd_wr();
      wr_enable = 1'($urandom_range(0, 1));
      wr_index  = 4'($urandom_range(0, 15));
      wr_value  = $urandom;
   endtask

   // Held operands must always match the architectural file contents.
   task automatic chk_bundle(input string tag);
      word obs [3];
      word e;
      obs[0] = rn_value; obs[1] = rm_value; obs[2] = rs_value;
      for (int i = 0; i < 3; i++) begin
         if (!m_use[i])     e = '0;
         else if (m_pcf[i]) e = m_pc + 32'd8;
         else               e = mem[m_idx[i]];
         chk($sformatf("%s.op%0d", tag, i), obs[i], e);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".rd_index"},  32'(rd_index),  32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      rn_use = 0; rm_use = 0; rs_use = 0; rn_pc = 0; rm_pc = 0; rs_pc = 0;
      rn_index = '0; rm_index = '0; rs_index = '0; pc = '0;
      wr_enable = 1'b0; wr_index = '0; wr_value = '0;
      m_use = '0; m_pcf = '0; m_pc = '0;
      for (int i = 0; i < 3; i++) m_idx[i] = '0;

      // Reset state
      #1;
      chk_idle("rst");
      chk("rst.rn", rn_value, 32'h0);
      chk("rst.rm", rm_value, 32'h0);
      chk("rst.rs", rs_value, 32'h0);
      step();
      rst = 1'b0;
      step();
      chk_idle("idle");
      for (int i = 0; i < 16; i++) wr_reg(4'(i), 32'h100 + 32'(i));

      // Three file reads
      wr_reg(4'd1, 32'h11); wr_reg(4'd2, 32'h22); wr_reg(4'd3, 32'h33);
      out_ready = 1'b1;
      req(3'b111, 3'b000, 4'd1, 4'd2, 4'd3, 32'h0);
      step(); in_valid = 1'b0;
      chk("r3.rd1", 32'(rd_index), 32'd1);
      chk("r3.busy", 32'(in_ready), 32'd0);
      step(); chk("r3.rd2", 32'(rd_index), 32'd2);
      step(); chk("r3.rd3", 32'(rd_index), 32'd3);
      step(); chk("r3.drain_rd", 32'(rd_index), 32'd0);
      chk("r3.drain_ov", 32'(out_valid), 32'd0);
      step(); chk("r3.ov", 32'(out_valid), 32'd1);
      chk("r3.rn", rn_value, 32'h11);
      chk("r3.rm", rm_value, 32'h22);
      chk("r3.rs", rs_value, 32'h33);
      step(); chk_idle("r3.after");

      // PC and unused operands
      wr_reg(4'd5, 32'hAA);
      req(3'b011, 3'b001, 4'd9, 4'd5, 4'd6, 32'h1000);
      step(); in_valid = 1'b0;
      chk("pc.rd", 32'(rd_index), 32'd5);
      step(); chk("pc.drain_ov", 32'(out_valid), 32'd0);
      step(); chk("pc.ov", 32'(out_valid), 32'd1);
      chk("pc.rn", rn_value, 32'h1008);
      chk("pc.rm", rm_value, 32'hAA);
      chk("pc.rs", rs_value, 32'h0);
      step(); chk_idle("pc.after");

      // Write landing in the capture cycle
      wr_reg(4'd4, 32'h1);
      req(3'b001, 3'b000, 4'd4, 4'd0, 4'd0, 32'h0);
      step(); in_valid = 1'b0;
      chk("cap.rd", 32'(rd_index), 32'd4);
      step();
      wr_enable = 1'b1; wr_index = 4'd4; wr_value = 32'h99;
      step(); wr_enable = 1'b0;
      chk("cap.ov", 32'(out_valid), 32'd1);
      chk("cap.rn", rn_value, 32'h99);
      step(); chk_idle("cap.after");

      // Hold snoop with backpressure
      out_ready = 1'b0;
      wr_reg(4'd7, 32'h07);
      req(3'b010, 3'b000, 4'd0, 4'd7, 4'd0, 32'h0);
      step(); in_valid = 1'b0;
      step(); step();
      chk("hold.ov", 32'(out_valid), 32'd1);
      chk("hold.rm0", rm_value, 32'h07);
      wr_reg(4'd7, 32'h77);
      chk("hold.rm1", rm_value, 32'h77);
      chk("hold.ov1", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step(); chk_idle("hold.hs");
      out_ready = 1'b0;
      step(); chk_idle("hold.hs2");

      // Flush during READ_RM
      req(3'b111, 3'b000, 4'd1, 4'd2, 4'd3, 32'h0);
      step(); in_valid = 1'b0;
      step(); chk("fl.rd", 32'(rd_index), 32'd2);
      flush = 1'b1;
      step(); flush = 1'b0;
      chk_idle("fl.next");
      for (int i = 0; i < 4; i++) begin
         step(); chk($sformatf("fl.ov%0d", i), 32'(out_valid), 32'd0);
      end

      // Async reset mid-read
      req(3'b111, 3'b000, 4'd1, 4'd2, 4'd3, 32'h0);
      step(); in_valid = 1'b0;
      step(); step();
      chk("ar.rn_cap", rn_value, 32'h11);
      #2 rst = 1'b1;
      #1;
      chk_idle("ar");
      chk("ar.rn", rn_value, 32'h0);
      chk("ar.rm", rm_value, 32'h0);
      #1 rst = 1'b0;
      step(); chk_idle("ar.rel");

      // Randomized requests with random writeback traffic
      for (int n = 0; n < 60; n++) begin
         logic [2:0] u, p;
         int k, hold_cycles;
         u = 3'($urandom_range(0, 7));
         p = 3'($urandom_range(0, 7));
         req(u, p, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom);
         out_ready = 1'b0;
         rnd_wr();
         step(); in_valid = 1'b0;
         k = 0;
         for (int i = 0; i < 3; i++) begin
            if (m_use[i] && !m_pcf[i]) begin
               chk($sformatf("rnd%0d.rd%0d", n, k), 32'(rd_index), 32'(m_idx[i]));
               chk($sformatf("rnd%0d.busy%0d", n, k), 32'(out_valid), 32'd0);
               k++;
               rnd_wr(); step();
            end
         end
         chk($sformatf("rnd%0d.drain", n), 32'(rd_index), 32'd0);
         chk($sformatf("rnd%0d.drain_ov", n), 32'(out_valid), 32'd0);
         rnd_wr(); step();
         hold_cycles = 0;
         forever begin
            chk($sformatf("rnd%0d.ov", n), 32'(out_valid), 32'd1);
            chk($sformatf("rnd%0d.inr", n), 32'(in_ready), 32'd0);
            chk_bundle($sformatf("rnd%0d", n));
            hold_cycles++;
            out_ready = (hold_cycles >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            rnd_wr(); step();
            if (out_ready) break;
         end
         out_ready = 1'b0;
         wr_enable = 1'b0;
         chk_idle($sformatf("rnd%0d.end", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
